// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU with RV32M multiply/divide.
package alu_pkg;

   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   typedef enum logic [4:0] {
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
      MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
   } alu_op_t;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU-control decode: main-control class plus funct fields to operation.
module alu_decode
   import alu_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7_b5,
   input  logic       funct7_b0,
   output alu_op_t    op
);

   always_comb begin
      op = ADD;
      if (alu_op == ALUOP_MEM) begin
         op = ADD;
      end else if (alu_op == ALUOP_BR) begin
         op = SUB;
      end else if (alu_op == ALUOP_R && funct7_b0) begin
         case (funct3)
            3'd0:    op = MUL;
            3'd1:    op = MULH;
            3'd2:    op = MULHSU;
            3'd3:    op = MULHU;
            3'd4:    op = DIV;
            3'd5:    op = DIVU;
            3'd6:    op = REM;
            default: op = REMU;
         endcase
      end else begin
         case (funct3)
            // I-type has no SUB; its bit 30 is immediate data except for shifts
            3'd0:    op = (alu_op == ALUOP_R && funct7_b5) ? SUB : ADD;
            3'd1:    op = SLL;
            3'd2:    op = SLT;
            3'd3:    op = SLTU;
            3'd4:    op = XOR;
            3'd5:    op = funct7_b5 ? SRA : SRL;
            3'd6:    op = OR;
            default: op = AND;
         endcase
      end
   end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Execute-stage ALU: single-cycle simple ops, bit-serial multiply and restoring divide.
module alu_muldiv_unit
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      alu_op,
   input  logic [2:0]      funct3,
   input  logic            funct7_b5,
   input  logic            funct7_b0,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int unsigned SHW = $clog2(XLEN);
   localparam int unsigned CW  = $clog2(XLEN);

   state_t            state;
   alu_op_t           dec_op;
   alu_op_t           op_q;
   logic [XLEN-1:0]   hi, lo, opnd;
   logic [CW-1:0]     cnt;
   logic              neg_q, neg_rem_q;

   logic              accept, is_mul, is_div, div_zero, div_ovf, a_sgn, b_sgn;
   logic [XLEN-1:0]   mag_a, mag_b, simple_res, special_res;
   logic [SHW-1:0]    shamt;
   logic [XLEN:0]     mul_sum, div_sh;
   logic [XLEN-1:0]   div_sub, step_hi, step_lo, quo, rem, final_res;
   logic              div_ok;
   logic [2*XLEN-1:0] prod, prod_c;

   alu_decode u_decode (
      .alu_op    (alu_op),
      .funct3    (funct3),
      .funct7_b5 (funct7_b5),
      .funct7_b0 (funct7_b0),
      .op        (dec_op)
   );

   always_comb begin
      in_ready = (state == IDLE) || (state == DONE && out_ready);
      accept   = in_valid && in_ready;
   end

   // Accept-side decode: operand magnitudes, sign flags, special divides, simple results
   always_comb begin
      is_mul   = dec_op inside {MUL, MULH, MULHSU, MULHU};
      is_div   = dec_op inside {DIV, DIVU, REM, REMU};
      a_sgn    = op_a[XLEN-1] && (dec_op inside {MUL, MULH, MULHSU, DIV, REM});
      b_sgn    = op_b[XLEN-1] && (dec_op inside {MUL, MULH, DIV, REM});
      mag_a    = a_sgn ? -op_a : op_a;
      mag_b    = b_sgn ? -op_b : op_b;
      div_zero = is_div && (op_b == '0);
      div_ovf  = (dec_op inside {DIV, REM}) && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
      shamt    = op_b[SHW-1:0];

      special_res = '0;
      if (dec_op inside {DIV, DIVU}) special_res = div_zero ? '1 : op_a;
      else                           special_res = div_zero ? op_a : '0;

      simple_res = '0;
      case (dec_op)
         ADD:     simple_res = op_a + op_b;
         SUB:     simple_res = op_a - op_b;
         SLL:     simple_res = op_a << shamt;
         SLT:     simple_res = XLEN'($signed(op_a) < $signed(op_b));
         SLTU:    simple_res = XLEN'(op_a < op_b);
         XOR:     simple_res = op_a ^ op_b;
         SRL:     simple_res = op_a >> shamt;
         SRA:     simple_res = XLEN'($signed(op_a) >>> shamt);
         OR:      simple_res = op_a | op_b;
         AND:     simple_res = op_a & op_b;
         default: simple_res = '0;
      endcase
   end

   // Iteration step: hi:lo is the product (shifts right) or remainder:quotient (shifts left)
   always_comb begin
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      div_sh  = {hi, lo[XLEN-1]};
      div_ok  = div_sh >= {1'b0, opnd};
      div_sub = div_sh[XLEN-1:0] - opnd;

      if (op_q inside {MUL, MULH, MULHSU, MULHU}) begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], lo[XLEN-1:1]};
      end else begin
         step_hi = div_ok ? div_sub : div_sh[XLEN-1:0];
         step_lo = {lo[XLEN-2:0], div_ok};
      end

      prod   = {step_hi, step_lo};
      prod_c = neg_q ? -prod : prod;
      quo    = neg_q ? -step_lo : step_lo;
      rem    = neg_rem_q ? -step_hi : step_hi;

      case (op_q)
         MUL:         final_res = prod_c[XLEN-1:0];
         DIV, DIVU:   final_res = quo;
         REM, REMU:   final_res = rem;
         default:     final_res = prod_c[2*XLEN-1:XLEN];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         busy      <= 1'b0;
         cnt       <= '0;
         hi        <= '0;
         lo        <= '0;
         opnd      <= '0;
         op_q      <= ADD;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         case (state)
            CALC: begin
               hi  <= step_hi;
               lo  <= step_lo;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(XLEN-1)) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  result    <= final_res;
                  cnt       <= '0;
               end
            end
            default: begin
               if (accept) begin
                  if ((is_mul || is_div) && !div_zero && !div_ovf) begin
                     state     <= CALC;
                     busy      <= 1'b1;
                     out_valid <= 1'b0;
                     cnt       <= '0;
                     hi        <= '0;
                     lo        <= is_mul ? mag_b : mag_a;
                     opnd      <= is_mul ? mag_a : mag_b;
                     op_q      <= dec_op;
                     neg_q     <= a_sgn ^ b_sgn;
                     neg_rem_q <= a_sgn;
                  end else begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     result    <= is_div ? special_res : simple_res;
                  end
               end else if (state == DONE && out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit: directed steps plus randomized ops against an arithmetic model.
module tb_alu_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  alu_op;
   logic [2:0]  funct3;
   logic        funct7_b5;
   logic        funct7_b0;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;

   int ncmp  = 0;
   int nfail = 0;

   alu_muldiv_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .funct3    (funct3),
      .funct7_b5 (funct7_b5),
      .funct7_b0 (funct7_b0),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: RISC-V semantics from plain 64-bit arithmetic; lat is cycles from accept to out_valid
   function automatic logic [31:0] model(input logic [1:0] aop, input logic [2:0] f3,
                                         input logic b5, input logic b0,
                                         input logic [31:0] a, input logic [31:0] b,
                                         output int lat);
      longint           sa, sb, ua, ub;
      logic [63:0]      p;
      logic signed [31:0] t;
      logic [31:0]      r;
      sa = $signed(a); sb = $signed(b);
      ua = {32'b0, a}; ub = {32'b0, b};
      t = a;
      lat = 1;
      r = 32'h0;
      if (aop == 2'b00) r = a + b;
      else if (aop == 2'b01) r = a - b;
      else if (aop == 2'b10 && b0) begin
         lat = 33;
         case (f3)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: if (b == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = a; lat = 1; end
                  else begin p = sa / sb; r = p[31:0]; end
            3'd5: if (b == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
                  else r = a / b;
            3'd6: if (b == 0) begin r = a; lat = 1; end
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = 0; lat = 1; end
                  else begin p = sa % sb; r = p[31:0]; end
            default: if (b == 0) begin r = a; lat = 1; end
                     else r = a % b;
         endcase
      end else begin
         case (f3)
            3'd0: r = (aop == 2'b10 && b5) ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = b5 ? 32'(t >>> b[4:0]) : a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
         endcase
      end
      return r;
   endfunction

   // Issue one op with out_ready high; inputs are scrambled after the accept edge
   task automatic run_op(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                         input logic b5, input logic b0, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int nbusy);
      int w;
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      chk({tag, ".in_ready"}, in_ready, 1'b1);
      in_valid = 1'b1; alu_op = aop; funct3 = f3; funct7_b5 = b5; funct7_b0 = b0;
      op_a = a; op_b = b;
      @(negedge clk);
      in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
      funct3 = 3'($urandom); alu_op = 2'($urandom);
      lat = 1; nbusy = 0;
      while (!out_valid && lat < 100) begin
         if (busy) nbusy++;
         @(negedge clk);
         lat++;
      end
      res = result;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   logic [31:0] res, exp_r, ra, rb;
   int          lat, nbusy, exp_lat, seen;
   logic [1:0]  raop;
   logic [2:0]  rf3;
   logic        rb5, rb0;
   logic [31:0] bq_exp;

   initial begin
      rst = 1'b1; in_valid = 1'b1; alu_op = 2'b00; funct3 = 3'd0; funct7_b5 = 1'b0;
      funct7_b0 = 1'b0; op_a = 32'd1; op_b = 32'd2; out_ready = 1'b1;

      // reset with in_valid high
      @(negedge clk); @(negedge clk);
      chk("rst.out_valid", out_valid, 1'b0);
      chk("rst.result", result, 32'h0);
      chk("rst.busy", busy, 1'b0);
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("rst.in_ready", in_ready, 1'b1);

      // R-type SUB, then I-type with the same fields decodes as ADD
      run_op("sub", 2'b10, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7, res, lat, nbusy);
      chk("sub.result", res, 32'hFFFF_FFFE);
      chk("sub.lat", lat, 1);
      run_op("iadd", 2'b11, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7, res, lat, nbusy);
      chk("iadd.result", res, 32'd12);
      chk("iadd.lat", lat, 1);

      run_op("mulh", 2'b10, 3'd1, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, res, lat, nbusy);
      chk("mulh.result", res, 32'h4000_0000);
      chk("mulh.lat", lat, 33);
      chk("mulh.busy", nbusy, 32);
      run_op("mulhsu", 2'b10, 3'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, res, lat, nbusy);
      chk("mulhsu.result", res, 32'hFFFF_FFFF);

      run_op("div", 2'b10, 3'd4, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, res, lat, nbusy);
      chk("div.result", res, 32'hFFFF_FFFD);
      chk("div.lat", lat, 33);
      run_op("rem", 2'b10, 3'd6, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, res, lat, nbusy);
      chk("rem.result", res, 32'hFFFF_FFFF);
      run_op("divu0", 2'b10, 3'd5, 1'b0, 1'b1, 32'd1234, 32'd0, res, lat, nbusy);
      chk("divu0.result", res, 32'hFFFF_FFFF);
      chk("divu0.lat", lat, 1);
      run_op("divovf", 2'b10, 3'd4, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, nbusy);
      chk("divovf.result", res, 32'h8000_0000);
      chk("divovf.busy", nbusy, 0);
      chk("divovf.lat", lat, 1);

      // backpressure: result held, then release together with a new op
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; alu_op = 2'b00; op_a = 32'd3; op_b = 32'd4;
      @(negedge clk);
      in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
      chk("bp.valid0", out_valid, 1'b1);
      chk("bp.result0", result, 32'd7);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp.valid", out_valid, 1'b1);
         chk("bp.result", result, 32'd7);
         chk("bp.in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      in_valid = 1'b1; alu_op = 2'b11; funct3 = 3'd4; funct7_b5 = 1'b0; funct7_b0 = 1'b0;
      op_a = 32'hF0F0_1234; op_b = 32'h0FF0_FFFF;
      #1 chk("bp.in_ready_rel", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp.next_valid", out_valid, 1'b1);
      chk("bp.next_result", result, 32'hFF00_EDCB);

      // reset during CALC of a DIVU discards it
      @(negedge clk);
      in_valid = 1'b1; alu_op = 2'b10; funct3 = 3'd5; funct7_b0 = 1'b1;
      op_a = 32'd1000; op_b = 32'd7;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) @(negedge clk);
      chk("rstcalc.busy", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstcalc.busy_after", busy, 1'b0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen++;
         @(negedge clk);
      end
      chk("rstcalc.no_valid", seen, 0);
      run_op("rstcalc.add", 2'b00, 3'd0, 1'b0, 1'b0, 32'd100, 32'd23, res, lat, nbusy);
      chk("rstcalc.add.result", res, 32'd123);
      chk("rstcalc.add.lat", lat, 1);

      // back-to-back simple ops, one result per cycle
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         raop = 2'b11; rf3 = 3'($urandom_range(0, 7)); rb5 = 1'($urandom);
         ra = $urandom; rb = $urandom;
         in_valid = 1'b1; alu_op = raop; funct3 = rf3; funct7_b5 = rb5; funct7_b0 = 1'b0;
         op_a = ra; op_b = rb;
         if (i > 0) begin
            chk("b2b.valid", out_valid, 1'b1);
            chk("b2b.result", result, bq_exp);
         end
         bq_exp = model(raop, rf3, rb5, 1'b0, ra, rb, exp_lat);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("b2b.valid_last", out_valid, 1'b1);
      chk("b2b.result_last", result, bq_exp);

      // randomized ops over every class
      for (int i = 0; i < 60; i++) begin
         raop = 2'($urandom); rf3 = 3'($urandom); rb5 = 1'($urandom);
         rb0 = ($urandom_range(0, 1) == 1);
         ra = pick(); rb = pick();
         exp_r = model(raop, rf3, rb5, rb0, ra, rb, exp_lat);
         run_op("rand", raop, rf3, rb5, rb0, ra, rb, res, lat, nbusy);
         chk($sformatf("rand%0d.result op=%0d f3=%0d b5=%0d b0=%0d a=%h b=%h", i, raop, rf3, rb5, rb0, ra, rb),
             res, exp_r);
         chk($sformatf("rand%0d.lat", i), lat, exp_lat);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/alu_muldiv_unit.md
# alu_muldiv_unit

Parametrised execute-stage ALU for the multi-cycle core: it fuses ALU-control decode with the datapath and adds the RV32M multiply/divide ops. Simple ops complete in one cycle; MUL*/DIV*/REM* run a bit-serial state machine. Upstream is the decode/issue stage and downstream the writeback register; both sides use valid/ready handshakes.

## Interface
- XLEN, default 32: operand and result width; any value ≥ 8.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  issue stage presents an operation.
- in_ready  out  1  unit accepts an operation this cycle.
- alu_op  in  2  main-control class: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- funct3  in  3  instruction bits 14:12.
- funct7_b5  in  1  instruction bit 30.
- funct7_b0  in  1  instruction bit 25 (M-extension select).
- op_a  in  XLEN  rs1 value.
- op_b  in  XLEN  rs2 or immediate.
- out_valid  out  1  result is valid.
- out_ready  in  1  writeback accepts the result.
- result  out  XLEN  operation result.
- busy  out  1  iterative operation in progress (state CALC).

## Operation
- Decode, on an in_valid && in_ready cycle:
  - 00 → ADD.
  - 01 → SUB.
  - 10 with funct7_b0=1 → M op by funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
  - 10 with funct7_b0=0 → by funct3: 0 ADD/SUB (funct7_b5), 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL/SRA (funct7_b5), 6 OR, 7 AND.
  - 11 → same as 10 with funct7_b0=0, except funct3=0 is always ADD; funct7_b5 is honoured only for funct3=5.
- Shift amount is op_b[$clog2(XLEN)-1:0]. SLT and SLTU return 0 or 1, zero-extended.
- States:
  - IDLE: accept an op. Simple op → result registered, go to DONE. M op → latch magnitudes and sign flags, clear the counter, go to CALC. Special divides skip CALC and go straight to DONE.
  - CALC: one shift-add (multiply) or restoring subtract (divide) step per cycle. After XLEN steps, apply sign correction, register result, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE; or go to CALC/DONE directly if a new op is accepted in the same cycle.
- Multiply: 2·XLEN-bit product of magnitudes, negated when the operand signs differ (signed/unsigned per op). MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide special cases, fixed:
  - op_b=0: quotient all-ones, remainder op_a.
  - Signed op_a=most-negative and op_b=−1: quotient op_a, remainder 0.
- Remainder sign follows the dividend; quotient is negated when the signs differ.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- result and out_valid are stable while out_valid && !out_ready.

## Timing
- Reset: state IDLE, out_valid 0, result 0, busy 0, counter 0, in_ready 1 the cycle after reset. Reset during CALC or DONE discards the op with no output.
- Simple op or special divide accepted at edge N → out_valid from edge N+1.
- M op accepted at edge N → busy for edges N+1..N+XLEN → out_valid from edge N+XLEN+1 (33 cycles at XLEN=32).
- Back-to-back simple ops with out_ready held high: one result per cycle.
- in_valid during CALC is ignored (in_ready=0), and the upstream holds it.
- Inputs are sampled only on the accept edge; later changes to op_a or op_b have no effect.

## Structure
- Package alu_pkg:
  - alu_op_t enum, 5-bit: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - state_t enum: IDLE, CALC, DONE.
  - alu_op class localparams: ALUOP_MEM=2'b00, ALUOP_BR=2'b01, ALUOP_R=2'b10, ALUOP_I=2'b11.
- Sub-module alu_decode: combinational map from {alu_op, funct7_b5, funct7_b0, funct3} to alu_op_t, instantiated once. The iterative datapath and FSM stay in the top module.

## Test plan
- Reset with in_valid high → out_valid 0, result 0, busy 0; in_ready 1 one cycle later.
- alu_op=10, funct3=0, funct7_b5=1, op_a=5, op_b=7, out_ready=1 → one cycle later result=0xFFFFFFFE; then alu_op=11 with the same fields → ADD, result=12.
- MULH, op_a=0x80000000, op_b=0x80000000 → busy exactly 32 cycles, result=0x40000000 on cycle 33; MULHSU, op_a=−1, op_b=2 → result=0xFFFFFFFF.
- DIV, op_a=−7, op_b=2 → quotient 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU by 0 → 0xFFFFFFFF in 1 cycle; DIV 0x80000000 by −1 → 0x80000000 with no busy.
- Hold out_ready low for 5 cycles after a result → result and out_valid stable, in_ready 0; raise out_ready with a new in_valid in the same cycle → new op accepted that cycle.
- Assert rst at CALC cycle 10 of a DIVU → no out_valid afterwards; the next ADD completes with correct latency.
